vga_timing_receiver: RTL and testbench

VGA_TIMING_RECEIVER -- requirements
Module: vga_timing_receiver

---
 rtl/vga_timing_receiver_if.sv | 11 +
 rtl/vga_timing_receiver.sv | 171 +++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_receiver_if.sv
// Incoming VGA video stream: active-low syncs plus 10-bit RGB, all on the pixel clock.
interface vga_timing_receiver_if;
  logic       iH_SYNC;
  logic       iV_SYNC;
  logic [9:0] iRed;
  logic [9:0] iGreen;
  logic [9:0] iBlue;

  modport master (output iH_SYNC, iV_SYNC, iRed, iGreen, iBlue);
  modport slave  (input  iH_SYNC, iV_SYNC, iRed, iGreen, iBlue);
endinterface

// File: rtl/vga_timing_receiver.sv
// VGA timing receiver: measures sync timing, locks to the expected mode and
// emits active-area pixels with coordinates, two clocks behind the inputs.
module vga_timing_receiver #(
  parameter int unsigned H_SYNC_CYC   = 96,
  parameter int unsigned H_SYNC_BACK  = 48,
  parameter int unsigned H_SYNC_ACT   = 640,
  parameter int unsigned H_SYNC_TOTAL = 800,
  parameter int unsigned V_SYNC_CYC   = 2,
  parameter int unsigned V_SYNC_BACK  = 33,
  parameter int unsigned V_SYNC_ACT   = 480,
  parameter int unsigned V_SYNC_TOTAL = 525
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  vga_timing_receiver_if.slave  vid,
  output logic [9:0]            oRed,
  output logic [9:0]            oGreen,
  output logic [9:0]            oBlue,
  output logic [9:0]            oCoord_X,
  output logic [9:0]            oCoord_Y,
  output logic                  oActive,
  output logic                  oFrameStart,
  output logic                  oLocked,
  output logic                  oErr,
  output logic [7:0]            oErrCnt,
  output logic [10:0]           oH_TOTAL,
  output logic [10:0]           oV_TOTAL
);

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned H_START = H_SYNC_CYC + H_SYNC_BACK;
  localparam int unsigned H_END   = H_START + H_SYNC_ACT - 1;
  localparam int unsigned V_START = V_SYNC_CYC + V_SYNC_BACK;
  localparam int unsigned V_END   = V_START + V_SYNC_ACT - 1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic             r_hs1, r_vs1, r_hs_prev, r_vs_prev;
  logic [9:0]       r_red1, r_green1, r_blue1;
  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic [1:0]       r_state;
  logic             r_line_bad;

  logic             w_h_edge, w_v_edge;
  logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
  logic [CNT_W:0]   w_h_len, w_v_len;
  logic             w_h_bad, w_v_bad, w_h_hit_max;
  logic [1:0]       w_state_nxt;
  logic             w_line_bad_nxt, w_err, w_locked_nxt, w_win, w_active;

  // Stage 1: capture syncs/pixels and keep the previous sync values for edge detection.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_hs_prev <= 1'b1;
      r_vs_prev <= 1'b1;
      r_red1    <= '0;
      r_green1  <= '0;
      r_blue1   <= '0;
    end else begin
      r_hs1     <= vid.iH_SYNC;
      r_vs1     <= vid.iV_SYNC;
      r_hs_prev <= r_hs1;
      r_vs_prev <= r_vs1;
      r_red1    <= vid.iRed;
      r_green1  <= vid.iGreen;
      r_blue1   <= vid.iBlue;
    end
  end

  // Sync falling edges, current-cycle counters and closing line/frame lengths.
  always_comb begin
    w_h_edge    = r_hs_prev & ~r_hs1;
    w_v_edge    = r_vs_prev & ~r_vs1;
    w_h_cnt     = w_h_edge ? '0 : ((r_h_cnt == CNT_MAX) ? r_h_cnt : r_h_cnt + 1'b1);
    w_v_cnt     = w_v_edge ? '0 :
                  (w_h_edge ? ((r_v_cnt == CNT_MAX) ? r_v_cnt : r_v_cnt + 1'b1) : r_v_cnt);
    w_h_len     = {1'b0, r_h_cnt} + 12'd1;
    w_v_len     = w_h_edge ? ({1'b0, r_v_cnt} + 12'd1) : {1'b0, r_v_cnt};
    w_h_bad     = w_h_edge & (w_h_len != 12'(H_SYNC_TOTAL));
    w_v_bad     = (w_v_len != 12'(V_SYNC_TOTAL));
    w_h_hit_max = ~w_h_edge & (w_h_cnt == CNT_MAX);
    w_win       = (w_h_cnt >= 11'(H_START)) & (w_h_cnt <= 11'(H_END)) &
                  (w_v_cnt >= 11'(V_START)) & (w_v_cnt <= 11'(V_END));
  end

  // Lock FSM next state; a closing line is checked before its coincident V edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_line_bad_nxt = r_line_bad;
    w_err          = 1'b0;
    case (r_state)
      S_SEARCH: begin
        if (w_v_edge) begin
          w_state_nxt    = S_VERIFY;
          w_line_bad_nxt = 1'b0;
        end
      end
      S_VERIFY: begin
        if (w_h_hit_max) begin
          w_state_nxt = S_SEARCH;
        end else if (w_v_edge) begin
          w_line_bad_nxt = 1'b0;
          if (!r_line_bad && !w_h_bad && !w_v_bad) w_state_nxt = S_LOCKED;
        end else if (w_h_bad) begin
          w_line_bad_nxt = 1'b1;
        end
      end
      S_LOCKED: begin
        if (w_h_bad || (w_v_edge && w_v_bad) || w_h_hit_max) begin
          w_state_nxt = S_SEARCH;
          w_err       = 1'b1;
        end
      end
      default: w_state_nxt = S_SEARCH;
    endcase
    w_locked_nxt = (w_state_nxt == S_LOCKED);
    w_active     = w_win & w_locked_nxt;
  end

  // State register, counters and stage-2 outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= S_SEARCH;
      r_line_bad  <= 1'b0;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      oRed        <= '0;
      oGreen      <= '0;
      oBlue       <= '0;
      oCoord_X    <= '0;
      oCoord_Y    <= '0;
      oActive     <= 1'b0;
      oFrameStart <= 1'b0;
      oLocked     <= 1'b0;
      oErr        <= 1'b0;
      oErrCnt     <= '0;
      oH_TOTAL    <= '0;
      oV_TOTAL    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_line_bad  <= w_line_bad_nxt;
      r_h_cnt     <= w_h_cnt;
      r_v_cnt     <= w_v_cnt;
      oActive     <= w_active;
      oFrameStart <= w_v_edge;
      oLocked     <= w_locked_nxt;
      oErr        <= w_err;
      if (w_err && (oErrCnt != 8'hFF)) oErrCnt <= oErrCnt + 8'd1;
      if (w_h_edge) oH_TOTAL <= w_h_len[CNT_W-1:0];
      if (w_v_edge) oV_TOTAL <= w_v_len[CNT_W-1:0];
      if (w_active) begin
        oCoord_X <= 10'(w_h_cnt - 11'(H_START));
        oCoord_Y <= 10'(w_v_cnt - 11'(V_START));
        oRed     <= r_red1;
        oGreen   <= r_green1;
        oBlue    <= r_blue1;
      end else begin
        oRed     <= '0;
        oGreen   <= '0;
        oBlue    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver using a reduced 40x12 timing mode.
module tb_vga_timing_receiver;

  localparam int HC = 8, HB = 6, HA = 16, HT = 40;
  localparam int VC = 2, VB = 3, VA = 6, VT = 12;
  localparam int HS = HC + HB;   // first active column: 14
  localparam int VS = VC + VB;   // first active row: 5

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  always #5 iCLK = ~iCLK;

  vga_timing_receiver_if vid ();

  logic [9:0]  oRed, oGreen, oBlue, oCoord_X, oCoord_Y;
  logic        oActive, oFrameStart, oLocked, oErr;
  logic [7:0]  oErrCnt;
  logic [10:0] oH_TOTAL, oV_TOTAL;

  vga_timing_receiver #(
    .H_SYNC_CYC(HC), .H_SYNC_BACK(HB), .H_SYNC_ACT(HA), .H_SYNC_TOTAL(HT),
    .V_SYNC_CYC(VC), .V_SYNC_BACK(VB), .V_SYNC_ACT(VA), .V_SYNC_TOTAL(VT)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .vid(vid),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oCoord_X(oCoord_X), .oCoord_Y(oCoord_Y),
    .oActive(oActive), .oFrameStart(oFrameStart), .oLocked(oLocked),
    .oErr(oErr), .oErrCnt(oErrCnt), .oH_TOTAL(oH_TOTAL), .oV_TOTAL(oV_TOTAL)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle counter advanced at posedge, read by everything at negedge.
  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  // Output monitor.
  int act_cnt [0:15];
  int fs_cyc  [0:15];
  int fs_n = 0;
  int first_x = -1, first_y = -1, last_x = -1, last_y = -1;
  int ramp_err = 0, zero_err = 0;
  int err_rise = 0, err_hi = 0, err_cyc = -1, lock_cyc = -1;
  logic prev_err = 1'b0, prev_lock = 1'b0;

  initial for (int i = 0; i < 16; i++) begin act_cnt[i] = 0; fs_cyc[i] = -1; end

  always @(negedge iCLK) begin
    prev_err  <= oErr;
    prev_lock <= oLocked;
    if (oFrameStart && fs_n < 15) begin
      fs_n <= fs_n + 1;
      fs_cyc[fs_n + 1] <= cyc;
    end
    if (oActive) begin
      if (act_cnt[fs_n] == 0) begin first_x <= oCoord_X; first_y <= oCoord_Y; end
      act_cnt[fs_n] <= act_cnt[fs_n] + 1;
      last_x <= oCoord_X;
      last_y <= oCoord_Y;
      if (oRed !== 10'(oCoord_X + 10'(HS)) || oGreen !== 10'(oCoord_Y + 10'(VS)) ||
          oBlue !== (10'(oCoord_X + 10'(HS)) ^ 10'(oCoord_Y + 10'(VS))))
        ramp_err <= ramp_err + 1;
    end else if ((oRed | oGreen | oBlue) !== 10'd0) begin
      zero_err <= zero_err + 1;
    end
    if (oErr) begin
      err_hi <= err_hi + 1;
      if (!prev_err) begin err_rise <= err_rise + 1; err_cyc <= cyc; end
    end
    if (oLocked && !prev_lock) lock_cyc <= cyc;
  end

  // Stimulus: one pixel clock per call, inputs applied just after negedge.
  int line_cs [0:15];

  task automatic drive(input int hp, input int vp);
    vid.iH_SYNC = (hp >= HC);
    vid.iV_SYNC = (vp >= VC);
    vid.iRed    = 10'(hp);
    vid.iGreen  = 10'(vp);
    vid.iBlue   = 10'(hp ^ vp);
    @(negedge iCLK);
  endtask

  task automatic idle(input int n);
    vid.iH_SYNC = 1'b1;
    vid.iV_SYNC = 1'b1;
    vid.iRed    = '0;
    vid.iGreen  = '0;
    vid.iBlue   = '0;
    repeat (n) @(negedge iCLK);
  endtask

  task automatic gen_line(input int len, input int vp);
    line_cs[vp] = cyc;
    for (int hp = 0; hp < len; hp++) drive(hp, vp);
  endtask

  task automatic gen_frame(input int lines, input int short_vp);
    for (int vp = 0; vp < lines; vp++) gen_line((vp == short_vp) ? HT - 1 : HT, vp);
    #1;
  endtask

  int c0;

  initial begin
    idle(0);
    repeat (3) @(negedge iCLK);
    #1;
    chk("rst_locked",  oLocked, 0);
    chk("rst_active",  oActive, 0);
    chk("rst_errcnt",  oErrCnt, 0);
    chk("rst_htotal",  oH_TOTAL, 0);
    chk("rst_fs",      oFrameStart, 0);
    iRST_N = 1'b1;
    @(negedge iCLK);
    idle(3);

    // Three standard frames: lock one cycle after the second V edge.
    c0 = cyc;
    gen_frame(VT, -1);
    chk("f1_fs_cyc", fs_cyc[1], c0 + 2);
    chk("f1_nolock", oLocked, 0);
    gen_frame(VT, -1);
    gen_frame(VT, -1);
    chk("lock_cyc",  lock_cyc, fs_cyc[2]);
    chk("locked",    oLocked, 1);
    chk("h_total",   oH_TOTAL, HT);
    chk("v_total",   oV_TOTAL, VT);
    chk("act_f1",    act_cnt[1], 0);
    chk("act_f2",    act_cnt[2], HA * VA);
    chk("act_f3",    act_cnt[3], HA * VA);
    chk("first_x",   first_x, 0);
    chk("first_y",   first_y, 0);
    chk("last_x",    last_x, HA - 1);
    chk("last_y",    last_y, VA - 1);
    chk("no_err",    err_rise, 0);

    // Short line while locked: immediate unlock, relock after two more V edges.
    gen_frame(VT, 7);
    chk("short_err_cnt",  oErrCnt, 1);
    chk("short_err_cyc",  err_cyc, line_cs[8] + 2);
    chk("short_unlock",   oLocked, 0);
    chk("short_act",      act_cnt[4], 2 * HA + HA);
    gen_frame(VT, -1);
    chk("relock1_no",     oLocked, 0);
    gen_frame(VT, -1);
    chk("relock2_yes",    oLocked, 1);
    chk("act_f6",         act_cnt[6], HA * VA);

    // hsync stuck high while locked: error when h_cnt saturates.
    c0 = line_cs[VT - 1];
    idle(2100);
    #1;
    chk("sat_err_cyc",  err_cyc, c0 + 2049);
    chk("sat_errcnt",   oErrCnt, 2);
    chk("sat_unlock",   oLocked, 0);
    chk("sat_active",   oActive, 0);

    // Short frame during VERIFY: no lock, no error; next good frame locks.
    gen_frame(VT - 1, -1);
    gen_frame(VT, -1);
    chk("vshort_nolock", oLocked, 0);
    chk("vshort_vtot",   oV_TOTAL, VT - 1);
    chk("vshort_noerr",  err_rise, 2);
    gen_frame(VT, -1);
    chk("vshort_relock", oLocked, 1);
    chk("vshort_vtot2",  oV_TOTAL, VT);
    chk("err_width",     err_hi, 2);

    // Reset pulse in the middle of an active line.
    for (int vp = 0; vp < 7; vp++) gen_line(HT, vp);
    for (int hp = 0; hp <= 20; hp++) drive(hp, 7);
    iRST_N = 1'b0;
    #1;
    chk("mrst_active", oActive, 0);
    chk("mrst_locked", oLocked, 0);
    chk("mrst_red",    oRed, 0);
    chk("mrst_errcnt", oErrCnt, 0);
    chk("mrst_xcoord", oCoord_X, 0);
    chk("mrst_htotal", oH_TOTAL, 0);
    for (int hp = 21; hp < HT; hp++) begin
      if (hp == 25) iRST_N = 1'b1;
      drive(hp, 7);
    end
    for (int vp = 8; vp < VT; vp++) gen_line(HT, vp);
    #1;
    chk("mrst_no_fs",  fs_n, 10);
    gen_frame(VT, -1);
    chk("mrst_fs",     fs_n, 11);
    chk("mrst_nolock", oLocked, 0);
    gen_frame(VT, -1);
    chk("mrst_lock",   oLocked, 1);
    chk("mrst_act",    act_cnt[12], HA * VA);
    chk("mrst_errcnt2", oErrCnt, 0);

    chk("ramp_err", ramp_err, 0);
    chk("zero_err", zero_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
